// File: rtl/hack_video_pkg.sv
// Shared constants for the Hack screen scan-out: default raster timing,
// screen memory layout and the word-address helper.
package hack_video_pkg;

  localparam int unsigned H_ACTIVE_DEF = 512;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 64;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 256;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 22;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic [15:0] SCREEN_BASE   = 16'h4000;
  localparam int unsigned WORDS_PER_ROW = 32;

  localparam int unsigned HC_W   = 11;
  localparam int unsigned VC_W   = 10;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned COL_W  = $clog2(WORDS_PER_ROW);
  localparam int unsigned ADDR_W = ROW_W + COL_W;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/hack_video_timing.sv
// Raster counters and sync/blank/de decode; decode outputs are registered on
// ce_pix so they describe the pixel whose counter value was just consumed.
module hack_video_timing
  import hack_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce_pix,
  output logic [HC_W-1:0] hc,
  output logic [VC_W-1:0] vc,
  output logic            hsync,
  output logic            vsync,
  output logic            hblank,
  output logic            vblank,
  output logic            de
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d;
  logic h_act_s, v_act_s, h_sync_s, v_sync_s;

  assign h_act_s  = (hc_q < HC_W'(H_ACTIVE));
  assign v_act_s  = (vc_q < VC_W'(V_ACTIVE));
  assign h_sync_s = (hc_q >= HC_W'(H_ACTIVE + H_FP)) && (hc_q < HC_W'(H_ACTIVE + H_FP + H_SYNC));
  assign v_sync_s = (vc_q >= VC_W'(V_ACTIVE + V_FP)) && (vc_q < VC_W'(V_ACTIVE + V_FP + V_SYNC));

  always_comb begin
    hc_d     = hc_q;
    vc_d     = vc_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    de_d     = de_q;
    if (ce_pix) begin
      if (hc_q == HC_W'(H_TOTAL - 1)) begin
        hc_d = '0;
        if (vc_q == VC_W'(V_TOTAL - 1)) begin
          vc_d = '0;
        end else begin
          vc_d = vc_q + VC_W'(1);
        end
      end else begin
        hc_d = hc_q + HC_W'(1);
      end
      hsync_d  = h_sync_s ? SYNC_POL : ~SYNC_POL;
      vsync_d  = v_sync_s ? SYNC_POL : ~SYNC_POL;
      hblank_d = ~h_act_s;
      vblank_d = ~v_act_s;
      de_d     = h_act_s & v_act_s;
    end else begin
      de_d = de_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q     <= '0;
      vc_q     <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      de_q     <= de_d;
    end
  end

  assign hc     = hc_q;
  assign vc     = vc_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblank = hblank_q;
  assign vblank = vblank_q;
  assign de     = de_q;

endmodule

// File: rtl/hack_screen_scanout.sv
// Reads Hack screen RAM one word ahead of the beam and shifts it out LSB-first
// as a 1 bpp raster, aligned with the registered sync/blank/de outputs.
module hack_screen_scanout
  import hack_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [15:0]       ram_data,
  output logic              pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              de
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HC_W-1:0]   hc;
  logic [VC_W-1:0]   vc;
  logic              active_s, boundary_s, line_fetch_s, eol_s, fetch_s;
  logic [ROW_W-1:0]  row_s;
  logic [COL_W-1:0]  col_s;
  logic [15:0]       holding_q, holding_d, shifter_q, shifter_d;
  logic              pixel_q, pixel_d, ram_rd_q, ram_rd_d, rd_dly_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

  hack_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hc(hc), .vc(vc),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de)
  );

  assign active_s     = (hc < HC_W'(H_ACTIVE)) && (vc < VC_W'(V_ACTIVE));
  assign boundary_s   = active_s && (hc[3:0] == 4'd0);
  assign line_fetch_s = (vc < VC_W'(V_ACTIVE)) && (hc < HC_W'(H_ACTIVE - 16)) && (hc[3:0] == 4'd0);
  assign eol_s        = (hc == HC_W'(H_TOTAL - 16));

  // Group 0 of the next row is fetched late in the current line; the last
  // blanking line fetches row 0 so a frame never starts on stale data.
  always_comb begin
    fetch_s = 1'b0;
    row_s   = '0;
    col_s   = '0;
    if (line_fetch_s) begin
      fetch_s = 1'b1;
      row_s   = vc[ROW_W-1:0];
      col_s   = hc[COL_W+3:4] + COL_W'(1);
    end else if (eol_s && (vc < VC_W'(V_ACTIVE - 1))) begin
      fetch_s = 1'b1;
      row_s   = vc[ROW_W-1:0] + ROW_W'(1);
    end else if (eol_s && (vc == VC_W'(V_TOTAL - 1))) begin
      fetch_s = 1'b1;
    end else begin
      fetch_s = 1'b0;
    end
  end

  always_comb begin
    ram_rd_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    shifter_d  = shifter_q;
    pixel_d    = pixel_q;
    holding_d  = rd_dly_q ? ram_data : holding_q;
    if (ce_pix) begin
      if (boundary_s) begin
        pixel_d   = holding_q[0];
        shifter_d = {1'b0, holding_q[15:1]};
      end else if (active_s) begin
        pixel_d   = shifter_q[0];
        shifter_d = {1'b0, shifter_q[15:1]};
      end else begin
        pixel_d = 1'b0;
      end
      if (fetch_s) begin
        ram_rd_d   = 1'b1;
        ram_addr_d = word_addr(row_s, col_s);
      end else begin
        ram_rd_d = 1'b0;
      end
    end else begin
      pixel_d = pixel_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holding_q  <= '0;
      shifter_q  <= '0;
      pixel_q    <= 1'b0;
      ram_rd_q   <= 1'b0;
      rd_dly_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      holding_q  <= holding_d;
      shifter_q  <= shifter_d;
      pixel_q    <= pixel_d;
      ram_rd_q   <= ram_rd_d;
      rd_dly_q   <= ram_rd_q;
      ram_addr_q <= ram_addr_d;
    end
  end

  assign pixel    = pixel_q;
  assign ram_rd   = ram_rd_q;
  assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Directed bench for hack_screen_scanout on a shrunken 80x14 raster
// (64x8 active) backed by a synchronous one-cycle-latency RAM model.
module tb_hack_screen_scanout;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset, ce_pix;
  logic [12:0] ram_addr;
  logic        ram_rd;
  logic [15:0] ram_data;
  logic        pixel, hsync, vsync, hblank, vblank, de;
  logic [15:0] mem [0:8191];

  int errors = 0, checks = 0;
  int de_cnt, hs_cnt, vs_cnt, hb_cnt, vb_cnt, hs_first, vs_first;
  int rd_cnt, rd_extra, addr_bad, pix_bad, hold_bad, ones, first_one, last_one;

  hack_screen_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .ram_addr(ram_addr), .ram_rd(ram_rd),
    .ram_data(ram_data), .pixel(pixel), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .de(de)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd) ram_data <= mem[ram_addr];
  end

  // k-th read of a frame: columns 1..3 of row r, then column 0 of the next row (row 0 wraps).
  function automatic int exp_addr(input int k);
    int r, c;
    r = k / 4;
    c = k % 4;
    if (c < 3) return r * 32 + c + 1;
    return ((r + 1) % VA) * 32;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input int n, input int div, input bit first);
    int dex, x, y;
    logic [15:0] w;
    logic e, p0, d0, h0, v0, hb0, vb0;
    dex = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; hb_cnt = 0; vb_cnt = 0;
    hs_first = -1; vs_first = -1; rd_cnt = 0; rd_extra = 0; addr_bad = 0;
    pix_bad = 0; hold_bad = 0; ones = 0; first_one = -1; last_one = -1;
    for (int i = 0; i < n; i++) begin
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
      if (de === 1'b1) begin
        x = dex % HA;
        y = dex / HA;
        w = mem[y * 32 + x / 16];
        e = w[x % 16];
        if (first && y == 0 && x < 16) e = 1'b0;
        if (pixel !== e) pix_bad++;
        if (pixel === 1'b1) begin
          ones++;
          if (first_one < 0) first_one = dex;
          last_one = dex;
        end
        de_cnt++;
        dex++;
      end else if (pixel !== 1'b0) begin
        pix_bad++;
      end
      if (hsync === 1'b0) begin hs_cnt++; if (hs_first < 0) hs_first = i; end
      if (vsync === 1'b0) begin vs_cnt++; if (vs_first < 0) vs_first = i; end
      if (hblank === 1'b1) hb_cnt++;
      if (vblank === 1'b1) vb_cnt++;
      if (ram_rd === 1'b1) begin
        if (rd_cnt < 32 && ram_addr !== 13'(exp_addr(rd_cnt))) addr_bad++;
        rd_cnt++;
      end
      p0 = pixel; d0 = de; h0 = hsync; v0 = vsync; hb0 = hblank; vb0 = vblank;
      for (int k = 1; k < div; k++) begin
        @(negedge clk);
        if (pixel !== p0 || de !== d0 || hsync !== h0 || vsync !== v0 ||
            hblank !== hb0 || vblank !== vb0) hold_bad++;
        if (ram_rd !== 1'b0) rd_extra++;
      end
    end
  endtask

  task automatic check_frame(input string f);
    chk({f, ".de_count"}, de_cnt, HA * VA);
    chk({f, ".hsync_low"}, hs_cnt, HS * VT);
    chk({f, ".vsync_low"}, vs_cnt, VS * HT);
    chk({f, ".hblank_count"}, hb_cnt, (HT - HA) * VT);
    chk({f, ".vblank_count"}, vb_cnt, (VT - VA) * HT);
    chk({f, ".hsync_first"}, hs_first, HA + HF);
    chk({f, ".vsync_first"}, vs_first, (VA + VF) * HT);
    chk({f, ".reads"}, rd_cnt, VA * 4);
    chk({f, ".addr_order_bad"}, addr_bad, 0);
    chk({f, ".pixel_bad"}, pix_bad, 0);
    chk({f, ".hold_bad"}, hold_bad, 0);
    chk({f, ".rd_extra"}, rd_extra, 0);
  endtask

  task automatic check_reset_outputs(input string f);
    chk({f, ".pixel"}, int'(pixel), 0);
    chk({f, ".de"}, int'(de), 0);
    chk({f, ".hsync"}, int'(hsync), 1);
    chk({f, ".vsync"}, int'(vsync), 1);
    chk({f, ".hblank"}, int'(hblank), 0);
    chk({f, ".vblank"}, int'(vblank), 0);
    chk({f, ".ram_rd"}, int'(ram_rd), 0);
    chk({f, ".ram_addr"}, int'(ram_addr), 0);
  endtask

  initial begin
    reset = 1'b0;
    ce_pix = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = 16'h0000;
    mem[0] = 16'h0001;
    mem[5 * 32 + 3] = 16'h8000;
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Frame after reset: row 0 group 0 was never prefetched.
    reset = 1'b0;
    scan(FRAME, 1, 1'b1);
    check_frame("f1");
    chk("f1.ones", ones, 1);
    chk("f1.one_pos", first_one, 5 * HA + 63);

    scan(FRAME, 1, 1'b0);
    check_frame("f2");
    chk("f2.ones", ones, 2);
    chk("f2.first_one", first_one, 0);
    chk("f2.last_one", last_one, 5 * HA + 63);

    // Alternating pattern at one enable every third clock.
    reset = 1'b1;
    for (int a = 0; a < 8192; a++) mem[a] = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    scan(FRAME, 3, 1'b1);
    check_frame("f3");
    chk("f3.ones", ones, VA * HA / 2 - 8);
    scan(FRAME, 3, 1'b0);
    check_frame("f4");
    chk("f4.ones", ones, VA * HA / 2);
    chk("f4.first_one", first_one, 1);

    // Reset in the middle of an active line, at an ink pixel.
    scan(2 * HT + 41 + 1, 1, 1'b0);
    chk("mid.pixel_before", int'(pixel), 1);
    chk("mid.de_before", int'(de), 1);
    chk("mid.addr_before", int'(ram_addr), 2 * 32 + 3);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    scan(FRAME, 1, 1'b1);
    check_frame("f5");
    chk("f5.ones", ones, VA * HA / 2 - 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
